neuron_accumulator: RTL and testbench

//  Serial multiply-accumulate collector in front of the neuron activation stage.

---
 rtl/neuron_accumulator.sv | 94 +++++++++
 tb/tb_neuron_accumulator.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/neuron_accumulator.sv
// Serial per-lane accumulator: sums NP beats of NC signed products into one
// output beat of NC sign-extended sums, overlapping the next frame with the held result.
module neuron_accumulator #(
    parameter int NP = 4,
    parameter int NC = 4,
    parameter int WF = 4,
    localparam int WA = $clog2(NP) + 1 + WF
) (
    input  logic             iCLK,
    input  logic             iRST,
    input  logic             iValid_AM_Prod,
    output logic             oReady_AM_Prod,
    input  logic [NC*WF-1:0] iData_AM_Prod,
    output logic             oValid_BM_Accum0,
    input  logic             iReady_BM_Accum0,
    output logic [NC*WA-1:0] oData_BM_Accum0
);

    localparam int CW = $clog2(NP);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } outState_t;

    outState_t     state_reg;
    outState_t     state_next;
    logic [CW-1:0] r_cnt;
    logic          lastBeat;
    logic          beatAccept;
    logic          lastAccept;
    logic          drain;

    assign lastBeat         = (r_cnt == CW'(NP - 1));
    assign oValid_BM_Accum0 = (state_reg == FULL);
    // Only the closing beat can collide with a held, undrained result.
    assign oReady_AM_Prod   = !(lastBeat && oValid_BM_Accum0 && !iReady_BM_Accum0);
    assign beatAccept       = iValid_AM_Prod && oReady_AM_Prod;
    assign lastAccept       = beatAccept && lastBeat;
    assign drain            = oValid_BM_Accum0 && iReady_BM_Accum0;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            EMPTY:   if (lastAccept) state_next = FULL;
            FULL:    if (drain && !lastAccept) state_next = EMPTY;
            default: state_next = EMPTY;
        endcase
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            state_reg <= EMPTY;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            r_cnt <= '0;
        end else if (beatAccept) begin
            r_cnt <= lastBeat ? '0 : r_cnt + CW'(1);
        end
    end

    for (genvar gi = 0; gi < NC; gi++) begin : gLane
        logic signed [WF-1:0] prod;
        logic signed [WA-1:0] prodExt;
        logic signed [WA-1:0] laneSum;
        logic signed [WA-1:0] r_acc;
        logic        [WA-1:0] sumReg;

        assign prod    = iData_AM_Prod[gi*WF +: WF];
        assign prodExt = {{(WA - WF){prod[WF-1]}}, prod};
        // Beat 0 starts a fresh frame directly, so no clear cycle is needed.
        assign laneSum = ((r_cnt == '0) ? '0 : r_acc) + prodExt;

        always_ff @(posedge iCLK or posedge iRST) begin
            if (iRST) begin
                r_acc  <= '0;
                sumReg <= '0;
            end else if (beatAccept) begin
                r_acc <= laneSum;
                if (lastBeat) begin
                    sumReg <= laneSum;
                end
            end
        end

        assign oData_BM_Accum0[gi*WA +: WA] = sumReg;
    end

endmodule

// File: tb/tb_neuron_accumulator.sv
// Directed bench for neuron_accumulator: a per-beat model pushes expected frame
// sums into a queue, and a monitor pops and compares them at every output transfer.
module tb_neuron_accumulator;

    localparam int NP = 4;
    localparam int NC = 2;
    localparam int WF = 4;
    localparam int WA = 7;

    logic             clk    = 1'b0;
    logic             rst    = 1'b1;
    logic             iValid = 1'b0;
    logic             iReady = 1'b1;
    logic [NC*WF-1:0] iData  = '0;
    logic             oReady;
    logic             oValid;
    logic [NC*WA-1:0] oData;

    int checks   = 0;
    int failures = 0;
    int outCount = 0;
    int accA     = 0;
    int accB     = 0;
    int beatN    = 0;
    int curA     = 0;
    int curB     = 0;
    logic [NC*WA-1:0] expQ[$];

    always #5 clk = ~clk;

    neuron_accumulator #(
        .NP(NP),
        .NC(NC),
        .WF(WF)
    ) dut (
        .iCLK            (clk),
        .iRST            (rst),
        .iValid_AM_Prod  (iValid),
        .oReady_AM_Prod  (oReady),
        .iData_AM_Prod   (iData),
        .oValid_BM_Accum0(oValid),
        .iReady_BM_Accum0(iReady),
        .oData_BM_Accum0 (oData)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    // Output side: every transfer must match the oldest outstanding frame sum.
    always @(negedge clk) begin
        logic [NC*WA-1:0] e;
        if (!rst && oValid && iReady) begin
            if (expQ.size() == 0) begin
                check("unexpected_output", 32'(oData), 32'hFFFF_FFFF);
            end else begin
                e = expQ.pop_front();
                outCount++;
                $display("OUT #%0d lane0=%0d lane1=%0d", outCount,
                         $signed(oData[WA-1:0]), $signed(oData[2*WA-1:WA]));
                check("out_sum", 32'(oData), 32'(e));
            end
        end
    end

    task automatic modelAccept();
        if (beatN == 0) begin
            accA = curA;
            accB = curB;
        end else begin
            accA += curA;
            accB += curB;
        end
        beatN++;
        if (beatN == NP) begin
            expQ.push_back({WA'(accB), WA'(accA)});
            beatN = 0;
        end
    endtask

    task automatic driveBeat(input int a, input int b);
        curA   = a;
        curB   = b;
        iData  = {WF'(b), WF'(a)};
        iValid = 1'b1;
    endtask

    // Entered after a rising edge; returns 1 time unit after the accepting edge.
    task automatic waitAccept(output int waited);
        logic rdy;
        waited = 0;
        forever begin
            #1;
            rdy = oReady;
            @(posedge clk);
            if (rdy) break;
            waited++;
            if (waited >= 40) begin
                check("accept_timeout", 32'(waited), 32'd0);
                #1;
                iValid = 1'b0;
                return;
            end
        end
        modelAccept();
        #1;
        $display("IN  lane0=%0d lane1=%0d stall=%0d", curA, curB, waited);
        if (beatN == 0) check("last_beat_latency", 32'(oValid), 32'd1);
        iValid = 1'b0;
    endtask

    task automatic sendBeat(input int a, input int b);
        int w;
        driveBeat(a, b);
        waitAccept(w);
        check("beat_no_stall", 32'(w), 32'd0);
    endtask

    task automatic sendFrame(input int a[NP], input int b[NP]);
        for (int i = 0; i < NP; i++) sendBeat(a[i], b[i]);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int fa[NP];
        int fb[NP];
        int w;
        logic [NC*WA-1:0] held;

        // Reset state
        idle(3);
        check("reset_valid", 32'(oValid), 32'd0);
        check("reset_data", 32'(oData), 32'd0);
        rst = 1'b0;
        #1;
        check("reset_ready", 32'(oReady), 32'd1);

        // Basic frame: lane0 = 5, lane1 = -32
        sendFrame('{1, 2, 3, -1}, '{-8, -8, -8, -8});
        check("t1_sum", 32'(oData), 32'({7'h60, 7'h05}));
        idle(2);

        // Back-to-back random frames, no backpressure
        for (int f = 0; f < 3; f++) begin
            for (int i = 0; i < NP; i++) begin
                fa[i] = int'($urandom_range(15, 0)) - 8;
                fb[i] = int'($urandom_range(15, 0)) - 8;
            end
            sendFrame(fa, fb);
        end
        idle(2);

        // Backpressure: last beat of frame 1 stalls until frame 0 drains
        iReady = 1'b0;
        sendFrame('{3, -4, 5, 2}, '{-1, -2, -3, 7});
        sendBeat(6, 1);
        sendBeat(-7, 1);
        sendBeat(0, 1);
        driveBeat(4, -5);
        held = expQ[0];
        check("t3_stall_ready", 32'(oReady), 32'd0);
        repeat (3) begin
            @(posedge clk);
            #1;
            check("t3_hold_valid", 32'(oValid), 32'd1);
            check("t3_hold_data", 32'(oData), 32'(held));
            check("t3_hold_ready", 32'(oReady), 32'd0);
        end
        iReady = 1'b1;
        waitAccept(w);
        check("t3_accept_with_drain", 32'(w), 32'd0);
        check("t3_frame1_valid", 32'(oValid), 32'd1);
        idle(2);

        // Gaps between beats give the same sums as the gapless frame
        driveBeat(1, -8);
        waitAccept(w);
        idle(2);
        driveBeat(2, -8);
        waitAccept(w);
        idle(1);
        driveBeat(3, -8);
        waitAccept(w);
        idle(3);
        driveBeat(-1, -8);
        waitAccept(w);
        check("t4_sum", 32'(oData), 32'({7'h60, 7'h05}));
        idle(2);

        // Async reset with a held result and a partial frame
        iReady = 1'b0;
        sendFrame('{5, 5, 5, 5}, '{-3, -3, -3, -3});
        sendBeat(7, 7);
        sendBeat(7, 7);
        sendBeat(7, 7);
        rst = 1'b1;
        #1;
        check("t5_reset_valid", 32'(oValid), 32'd0);
        check("t5_reset_data", 32'(oData), 32'd0);
        expQ.delete();
        beatN = 0;
        idle(2);
        rst    = 1'b0;
        iReady = 1'b1;
        #1;
        check("t5_ready_after_reset", 32'(oReady), 32'd1);
        sendFrame('{1, 1, 1, 1}, '{2, 2, 2, 2});
        check("t5_sum", 32'(oData), 32'({7'd8, 7'd4}));
        idle(2);

        // Extremes
        sendFrame('{7, 7, 7, 7}, '{-8, -8, -8, -8});
        check("t6_sum_a", 32'(oData), 32'({7'h60, 7'h1C}));
        sendFrame('{-8, -8, -8, -8}, '{7, 7, 7, 7});
        check("t6_sum_b", 32'(oData), 32'({7'h1C, 7'h60}));
        idle(3);

        check("queue_drained", 32'(expQ.size()), 32'd0);
        check("final_valid", 32'(oValid), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
